// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS register bank with scoreboard.
//   - Default data/address widths for the bank.
//   - State type of the sequenced clear engine.
//   - Address of the architectural zero register.
package mips_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  // Architectural zero register index (R0).
  localparam int unsigned REG_ZERO = 0;

  // Clear engine: idle, or sweeping one register per cycle.
  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_e;

endpackage

// File: rtl/mips_reg_scoreboard.sv
// Per-register pending (in-flight producer) scoreboard.
//   clk, reset   : clock, synchronous active-high reset
//   issue_eff_i  : qualified issue; sets pending[issue_dr_i]
//   write_eff_i  : qualified writeback; clears pending[dr_i]
//   clr_en_i     : clear sweep active; clears pending[clr_addr_i]
//   sr1_i/sr2_i  : decode source addresses
//   pend1_o/2_o  : source has an outstanding producer
module mips_reg_scoreboard
  import mips_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter bit ZERO_R0 = 1'b1,
  parameter bit BYPASS  = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              issue_eff_i,
  input  logic [ADDR_W-1:0] issue_dr_i,
  input  logic              write_eff_i,
  input  logic [ADDR_W-1:0] dr_i,
  input  logic              clr_en_i,
  input  logic [ADDR_W-1:0] clr_addr_i,
  input  logic [ADDR_W-1:0] sr1_i,
  input  logic [ADDR_W-1:0] sr2_i,
  output logic              pend1_o,
  output logic              pend2_o
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

  logic [DEPTH-1:0] pend_q;
  logic [DEPTH-1:0] pend_d;
  logic             fwd_clear;
  logic             fwd1;
  logic             fwd2;

  always_comb begin
    // NOTE: start from the held value so every path assigns pend_d; a
    // missing default in always_comb would infer a latch.
    pend_d = pend_q;
    if (clr_en_i)    pend_d[clr_addr_i] = 1'b0;
    if (write_eff_i) pend_d[dr_i]       = 1'b0;
    // Issued last so a same-cycle issue to the written register wins:
    // the new producer is still in flight.
    if (issue_eff_i) pend_d[issue_dr_i] = 1'b1;
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignment for all flop state so every reader
    // sees the pre-edge value regardless of block evaluation order.
    if (reset) pend_q <= '0;
    else       pend_q <= pend_d;
  end

  // A write landing this cycle already resolves the hazard when it is
  // forwarded, unless the same cycle re-claims that register.
  assign fwd_clear = BYPASS && write_eff_i && !(issue_eff_i && issue_dr_i == dr_i);
  assign fwd1      = fwd_clear && (dr_i == sr1_i);
  assign fwd2      = fwd_clear && (dr_i == sr2_i);

  assign pend1_o = (ZERO_R0 && sr1_i == ZERO_ADDR) ? 1'b0 : (pend_q[sr1_i] & ~fwd1);
  assign pend2_o = (ZERO_R0 && sr2_i == ZERO_ADDR) ? 1'b0 : (pend_q[sr2_i] & ~fwd2);

endmodule

// File: rtl/mips_reg_bank_sb.sv
// Parametrised MIPS register bank with RAW scoreboard and clear engine.
//   clk, reset     : clock, synchronous active-high reset
//   sr1/sr2        : read addresses; rd1/rd2 combinational read data
//   dr/wrData/write: writeback port
//   issue/issue_dr : claim issue_dr as pending at issue
//   pend1/pend2    : sr1/sr2 have an outstanding producer
//   clr_req        : start a DEPTH-cycle sweep zeroing every register
//   busy           : sweep in progress (writes and issues dropped)
module mips_reg_bank_sb
  import mips_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter bit ZERO_R0 = 1'b1,
  parameter bit BYPASS  = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] sr1,
  input  logic [ADDR_W-1:0] sr2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  input  logic [ADDR_W-1:0] dr,
  input  logic [DATA_W-1:0] wrData,
  input  logic              write,
  input  logic              issue,
  input  logic [ADDR_W-1:0] issue_dr,
  output logic              pend1,
  output logic              pend2,
  input  logic              clr_req,
  output logic              busy
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(DEPTH - 1);

  logic [DATA_W-1:0] regs_q [DEPTH];
  clr_state_e        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              write_eff;
  logic              issue_eff;

  assign busy      = (state_q == CLEAR);
  assign write_eff = write & ~busy & ~(ZERO_R0 && dr == ZERO_ADDR);
  assign issue_eff = issue & ~busy & ~(ZERO_R0 && issue_dr == ZERO_ADDR);

  // Clear engine: one register per cycle, terminal at the last index.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (clr_req) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        if (cnt_q == LAST_IDX) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ADDR_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: the array is reset explicitly because a bank reset must leave
  // every register reading zero; this forces flops rather than a RAM macro.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
    end else if (busy) begin
      regs_q[cnt_q] <= '0;
    end else if (write_eff) begin
      regs_q[dr] <= wrData;
    end
  end

  // Read mux: zero register, then same-cycle forward, then array.
  always_comb begin
    if (ZERO_R0 && sr1 == ZERO_ADDR)           rd1 = '0;
    else if (BYPASS && write_eff && dr == sr1) rd1 = wrData;
    else                                       rd1 = regs_q[sr1];

    if (ZERO_R0 && sr2 == ZERO_ADDR)           rd2 = '0;
    else if (BYPASS && write_eff && dr == sr2) rd2 = wrData;
    else                                       rd2 = regs_q[sr2];
  end

  mips_reg_scoreboard #(
    .ADDR_W  (ADDR_W),
    .ZERO_R0 (ZERO_R0),
    .BYPASS  (BYPASS)
  ) u_scoreboard (
    .clk         (clk),
    .reset       (reset),
    .issue_eff_i (issue_eff),
    .issue_dr_i  (issue_dr),
    .write_eff_i (write_eff),
    .dr_i        (dr),
    .clr_en_i    (busy),
    .clr_addr_i  (cnt_q),
    .sr1_i       (sr1),
    .sr2_i       (sr2),
    .pend1_o     (pend1),
    .pend2_o     (pend2)
  );

endmodule
